// File: rtl/quadra_pkg.sv
// rtl/quadra_pkg.sv - shared types and default sizes for the quadra result collector
package quadra_pkg;

    localparam int DEF_X_W        = 24;
    localparam int DEF_Y_W        = 44;
    localparam int DEF_TAGQ_DEPTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W      = 32;

    typedef logic [DEF_X_W-1:0] x_t;
    typedef logic [DEF_Y_W-1:0] y_t;
    typedef logic               dv_t;
    typedef logic               ck_t;
    typedef logic               rs_t;

    typedef struct packed {
        x_t x;
        y_t y;
    } pair_t;

endpackage

// File: rtl/quadra_result_collector_if.sv
// rtl/quadra_result_collector_if.sv - operand/result snoop, result drain and status bundle
interface quadra_result_collector_if #(
    parameter int X_W        = quadra_pkg::DEF_X_W,
    parameter int Y_W        = quadra_pkg::DEF_Y_W,
    parameter int FIFO_DEPTH = quadra_pkg::DEF_FIFO_DEPTH,
    parameter int CNT_W      = quadra_pkg::DEF_CNT_W
);
    logic [X_W-1:0]                x;
    logic                          x_dv;
    logic [Y_W-1:0]                y;
    logic                          y_dv;
    logic [X_W-1:0]                o_x;
    logic [Y_W-1:0]                o_y;
    logic                          o_vld;
    logic                          o_rdy;
    logic                          err_clr;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic [CNT_W-1:0]              pair_cnt;
    logic                          err_tagq;
    logic                          err_orph;
    logic                          err_ovf;

    modport master (
        output x, x_dv, y, y_dv, o_rdy, err_clr,
        input  o_x, o_y, o_vld, level, pair_cnt, err_tagq, err_orph, err_ovf
    );

    modport slave (
        input  x, x_dv, y, y_dv, o_rdy, err_clr,
        output o_x, o_y, o_vld, level, pair_cnt, err_tagq, err_orph, err_ovf
    );
endinterface

// File: rtl/quadra_sync_fifo.sv
// rtl/quadra_sync_fifo.sv - single-clock FIFO; push while full is taken only alongside a pop
module quadra_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/quadra_result_collector.sv
// rtl/quadra_result_collector.sv - pairs quadra results with their operands, buffers and drains them
module quadra_result_collector
    import quadra_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int TAGQ_DEPTH = DEF_TAGQ_DEPTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    quadra_result_collector_if.slave   bus
);
    localparam int PW = X_W + Y_W;

    logic [X_W-1:0]                   tag_head;
    logic                             tag_empty, tag_full;
    logic [$clog2(TAGQ_DEPTH):0]      unused_tag_level;
    logic [PW-1:0]                    res_head;
    logic                             res_empty, res_full;
    logic [$clog2(FIFO_DEPTH):0]      res_level;

    logic                             pair_vld, res_pop, res_accept;
    logic                             set_tagq, set_orph, set_ovf;
    logic                             err_tagq_q, err_tagq_d;
    logic                             err_orph_q, err_orph_d;
    logic                             err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0]                 pair_cnt_q, pair_cnt_d;

    // A y always consumes its tag, even if the resulting pair is dropped on overflow.
    quadra_sync_fifo #(.W(X_W), .DEPTH(TAGQ_DEPTH)) u_tagq (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.x_dv),
        .push_data (bus.x),
        .pop       (bus.y_dv),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .level     (unused_tag_level)
    );

    quadra_sync_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_resq (
        .clk       (clk),
        .rst       (rst),
        .push      (pair_vld),
        .push_data ({tag_head, bus.y}),
        .pop       (bus.o_rdy),
        .head      (res_head),
        .empty     (res_empty),
        .full      (res_full),
        .level     (res_level)
    );

    assign pair_vld   = bus.y_dv & ~tag_empty;
    assign res_pop    = ~res_empty & bus.o_rdy;
    assign res_accept = pair_vld & (~res_full | res_pop);

    assign set_tagq   = bus.x_dv & tag_full & ~bus.y_dv;
    assign set_orph   = bus.y_dv & tag_empty;
    assign set_ovf    = pair_vld & res_full & ~res_pop;

    always_comb begin
        err_tagq_d = set_tagq | (err_tagq_q & ~bus.err_clr);
        err_orph_d = set_orph | (err_orph_q & ~bus.err_clr);
        err_ovf_d  = set_ovf  | (err_ovf_q  & ~bus.err_clr);
        pair_cnt_d = pair_cnt_q;
        if (res_accept && (pair_cnt_q != '1)) pair_cnt_d = pair_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tagq_q <= 1'b0;
            err_orph_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            pair_cnt_q <= '0;
        end else begin
            err_tagq_q <= err_tagq_d;
            err_orph_q <= err_orph_d;
            err_ovf_q  <= err_ovf_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    assign bus.o_vld    = ~res_empty;
    assign bus.o_x      = res_head[PW-1:Y_W];
    assign bus.o_y      = res_head[Y_W-1:0];
    assign bus.level    = res_level;
    assign bus.pair_cnt = pair_cnt_q;
    assign bus.err_tagq = err_tagq_q;
    assign bus.err_orph = err_orph_q;
    assign bus.err_ovf  = err_ovf_q;
endmodule

// File: tb/tb_quadra_result_collector.sv
// tb/tb_quadra_result_collector.sv - directed and randomized checks against a queue-based reference model
module tb_quadra_result_collector;
    import quadra_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quadra_result_collector_if bus ();

    quadra_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    x_t              m_tq[$];
    x_t              m_rx[$];
    y_t              m_ry[$];
    longint unsigned m_cnt;
    bit              m_etagq, m_eorph, m_eovf;

    // One clock with the given inputs; the model advances on the same edge.
    task automatic drive_cycle(input bit xdv, input x_t xv, input bit ydv, input y_t yv,
                               input bit rdy, input bit clr);
        bit pop_o, t_full, t_empty, r_full, have;
        bit s_tagq, s_orph, s_ovf;
        x_t tag;
        bus.x = xv; bus.x_dv = xdv; bus.y = yv; bus.y_dv = ydv;
        bus.o_rdy = rdy; bus.err_clr = clr;
        s_tagq = 0; s_orph = 0; s_ovf = 0; have = 0; tag = '0;
        pop_o   = (m_rx.size() > 0) && rdy;
        t_full  = (m_tq.size() == DEF_TAGQ_DEPTH);
        t_empty = (m_tq.size() == 0);
        r_full  = (m_rx.size() == DEF_FIFO_DEPTH);
        if (ydv) begin
            if (t_empty) s_orph = 1;
            else begin tag = m_tq.pop_front(); have = 1; end
        end
        if (xdv) begin
            if (!t_full || ydv) m_tq.push_back(xv);
            else s_tagq = 1;
        end
        if (pop_o) begin void'(m_rx.pop_front()); void'(m_ry.pop_front()); end
        if (have) begin
            if (!r_full || pop_o) begin
                m_rx.push_back(tag); m_ry.push_back(yv);
                if (m_cnt != 64'hffff_ffff) m_cnt++;
            end else s_ovf = 1;
        end
        m_etagq = s_tagq | (m_etagq & !clr);
        m_eorph = s_orph | (m_eorph & !clr);
        m_eovf  = s_ovf  | (m_eovf  & !clr);
        @(posedge clk); #1;
        bus.x_dv = 0; bus.y_dv = 0; bus.o_rdy = 0; bus.err_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1; bus.o_rdy = 1; bus.x_dv = 1; bus.y_dv = 1; bus.err_clr = 0;
        @(posedge clk); #1;
        rst = 0; bus.o_rdy = 0; bus.x_dv = 0; bus.y_dv = 0;
        m_tq.delete(); m_rx.delete(); m_ry.delete();
        m_cnt = 0; m_etagq = 0; m_eorph = 0; m_eovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.o_vld, bus.level, bus.pair_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_counts: o_vld=%0b level=%0d pair_cnt=%0d expected all 0", bus.o_vld, bus.level, bus.pair_cnt);
        end
        total++;
        if ({bus.err_tagq, bus.err_orph, bus.err_ovf} !== 3'b000) begin
            bad++;
            $display("FAIL reset_errs: got %b%b%b expected 000", bus.err_tagq, bus.err_orph, bus.err_ovf);
        end
        total++;
        if ({bus.o_x, bus.o_y} !== '0) begin
            bad++;
            $display("FAIL reset_head: o_x=%h o_y=%h expected 0", bus.o_x, bus.o_y);
        end
    endtask

    task automatic test_single_op();
        drive_cycle(1, 24'h7fffff, 0, '0, 1, 0);
        drive_cycle(0, '0, 1, 44'h0123456789a, 1, 0);
        total++;
        if ({bus.o_vld, bus.o_x, bus.o_y} !== {1'b1, 24'h7fffff, 44'h0123456789a}) begin
            bad++;
            $display("FAIL single_beat: o_vld=%0b o_x=%h o_y=%h expected 1 7fffff 0123456789a", bus.o_vld, bus.o_x, bus.o_y);
        end
        total++;
        if ({bus.pair_cnt, bus.err_tagq, bus.err_orph, bus.err_ovf} !== {32'd1, 3'b000}) begin
            bad++;
            $display("FAIL single_cnt_err: pair_cnt=%0d errs=%b%b%b expected 1 000", bus.pair_cnt, bus.err_tagq, bus.err_orph, bus.err_ovf);
        end
        drive_cycle(0, '0, 0, '0, 1, 0);
        total++;
        if ({bus.o_vld, bus.level} !== 6'd0) begin
            bad++;
            $display("FAIL single_drained: o_vld=%0b level=%0d expected 0 0", bus.o_vld, bus.level);
        end
    endtask

    task automatic test_burst_overflow();
        x_t xs[16];
        y_t ys[16];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            xs[i] = x_t'($urandom);
            ys[i] = {12'($urandom), 32'($urandom)};
            drive_cycle(1, xs[i], 0, '0, 0, 0);
            drive_cycle(0, '0, 1, ys[i], 0, 0);
        end
        total++;
        if ({bus.level, bus.o_vld, bus.o_x, bus.o_y} !== {5'd16, 1'b1, xs[0], ys[0]}) begin
            bad++;
            $display("FAIL burst_full: level=%0d o_vld=%0b o_x=%h o_y=%h expected 16 1 %h %h", bus.level, bus.o_vld, bus.o_x, bus.o_y, xs[0], ys[0]);
        end
        drive_cycle(1, 24'h123456, 0, '0, 0, 0);
        drive_cycle(0, '0, 1, 44'habcdef, 0, 0);
        total++;
        if ({bus.err_ovf, bus.pair_cnt, bus.level} !== {1'b1, 32'd16, 5'd16}) begin
            bad++;
            $display("FAIL burst_ovf: err_ovf=%0b pair_cnt=%0d level=%0d expected 1 16 16", bus.err_ovf, bus.pair_cnt, bus.level);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({bus.o_vld, bus.o_x, bus.o_y} !== {1'b1, xs[i], ys[i]}) begin
                bad++;
                $display("FAIL burst_drain[%0d]: o_vld=%0b o_x=%h o_y=%h expected 1 %h %h", i, bus.o_vld, bus.o_x, bus.o_y, xs[i], ys[i]);
            end
            drive_cycle(0, '0, 0, '0, 1, 0);
        end
        total++;
        if ({bus.o_vld, bus.level} !== 6'd0) begin
            bad++;
            $display("FAIL burst_empty: o_vld=%0b level=%0d expected 0 0", bus.o_vld, bus.level);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1, x_t'(i + 1), 0, '0, 0, 0);
            drive_cycle(0, '0, 1, y_t'(i + 100), 0, 0);
        end
        drive_cycle(1, 24'h00beef, 0, '0, 0, 0);
        drive_cycle(0, '0, 1, 44'hfeed, 1, 0);
        total++;
        if ({bus.level, bus.err_ovf, bus.pair_cnt} !== {5'd16, 1'b0, 32'd17}) begin
            bad++;
            $display("FAIL full_pushpop: level=%0d err_ovf=%0b pair_cnt=%0d expected 16 0 17", bus.level, bus.err_ovf, bus.pair_cnt);
        end
        total++;
        if ({bus.o_x, bus.o_y} !== {24'd2, 44'd101}) begin
            bad++;
            $display("FAIL full_pushpop_head: o_x=%h o_y=%h expected 2 65", bus.o_x, bus.o_y);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        drive_cycle(0, '0, 1, 44'h1, 0, 0);
        total++;
        if ({bus.err_orph, bus.level} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL orphan_set: err_orph=%0b level=%0d expected 1 0", bus.err_orph, bus.level);
        end
        drive_cycle(0, '0, 0, '0, 0, 1);
        total++;
        if (bus.err_orph !== 1'b0) begin
            bad++;
            $display("FAIL orphan_clr: err_orph=%0b expected 0", bus.err_orph);
        end
        drive_cycle(0, '0, 1, 44'h2, 0, 1);
        total++;
        if (bus.err_orph !== 1'b1) begin
            bad++;
            $display("FAIL orphan_set_over_clr: err_orph=%0b expected 1", bus.err_orph);
        end
    endtask

    task automatic test_tagq_full();
        x_t xs[9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            xs[i] = x_t'($urandom);
            drive_cycle(1, xs[i], 0, '0, 0, 0);
        end
        total++;
        if (bus.err_tagq !== 1'b1) begin
            bad++;
            $display("FAIL tagq_err: err_tagq=%0b expected 1", bus.err_tagq);
        end
        for (int i = 0; i < 8; i++) drive_cycle(0, '0, 1, y_t'(i), 0, 0);
        total++;
        if ({bus.level, bus.err_orph} !== {5'd8, 1'b0}) begin
            bad++;
            $display("FAIL tagq_level: level=%0d err_orph=%0b expected 8 0", bus.level, bus.err_orph);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bus.o_x, bus.o_y} !== {xs[i], y_t'(i)}) begin
                bad++;
                $display("FAIL tagq_order[%0d]: o_x=%h o_y=%h expected %h %h", i, bus.o_x, bus.o_y, xs[i], y_t'(i));
            end
            drive_cycle(0, '0, 0, '0, 1, 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, x_t'(i), 0, '0, 0, 0);
            drive_cycle(0, '0, 1, y_t'(i), 0, 0);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1, x_t'(i + 50), 0, '0, 0, 0);
        drive_cycle(0, '0, 1, '0, 0, 0);
        drive_cycle(0, '0, 1, '0, 0, 0);
        drive_cycle(0, '0, 1, '0, 0, 0);
        drive_cycle(1, 24'h5, 0, '0, 0, 0);
        drive_cycle(1, 24'h6, 0, '0, 0, 0);
        drive_cycle(1, 24'h7, 0, '0, 0, 0);
        drive_cycle(0, '0, 0, '0, 0, 0);
        total++;
        if (bus.level !== 5'd8) begin
            bad++;
            $display("FAIL mid_prefill: level=%0d expected 8", bus.level);
        end
        do_reset();
        total++;
        if ({bus.o_vld, bus.level, bus.pair_cnt, bus.err_tagq, bus.err_orph, bus.err_ovf} !== '0) begin
            bad++;
            $display("FAIL mid_reset: o_vld=%0b level=%0d pair_cnt=%0d errs=%b%b%b expected all 0",
                     bus.o_vld, bus.level, bus.pair_cnt, bus.err_tagq, bus.err_orph, bus.err_ovf);
        end
        test_single_op();
    endtask

    task automatic test_random();
        int xr, yr, rr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                xr = $urandom_range(20, 90);
                yr = $urandom_range(20, 90);
                rr = $urandom_range(10, 95);
            end
            drive_cycle($urandom_range(0, 99) < xr, x_t'($urandom),
                        $urandom_range(0, 99) < yr, {12'($urandom), 32'($urandom)},
                        $urandom_range(0, 99) < rr, $urandom_range(0, 99) < 3);
            total++;
            if ({bus.o_vld, bus.level, bus.pair_cnt} !== {m_rx.size() != 0, 5'(m_rx.size()), 32'(m_cnt)}) begin
                bad++;
                $display("FAIL rand_state@%0d: o_vld=%0b level=%0d pair_cnt=%0d expected %0b %0d %0d",
                         c, bus.o_vld, bus.level, bus.pair_cnt, m_rx.size() != 0, m_rx.size(), m_cnt);
            end
            total++;
            if ({bus.err_tagq, bus.err_orph, bus.err_ovf} !== {m_etagq, m_eorph, m_eovf}) begin
                bad++;
                $display("FAIL rand_errs@%0d: got %b%b%b expected %b%b%b", c,
                         bus.err_tagq, bus.err_orph, bus.err_ovf, m_etagq, m_eorph, m_eovf);
            end
            if (m_rx.size() != 0) begin
                total++;
                if ({bus.o_x, bus.o_y} !== {m_rx[0], m_ry[0]}) begin
                    bad++;
                    $display("FAIL rand_head@%0d: o_x=%h o_y=%h expected %h %h", c, bus.o_x, bus.o_y, m_rx[0], m_ry[0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        bus.x = '0; bus.x_dv = 0; bus.y = '0; bus.y_dv = 0; bus.o_rdy = 0; bus.err_clr = 0;
        @(posedge clk); #1;
        test_reset();
        test_single_op();
        test_burst_overflow();
        test_full_push_pop();
        test_orphan();
        test_tagq_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
